// File: rtl/memd_arb_pkg.sv
// Shared types and defaults for the two-requester data-memory arbiter.
package memd_arb_pkg;
  localparam int AW_DEF        = 5;
  localparam int DW_DEF        = 32;
  localparam int MAX_BURST_DEF = 4;
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;
endpackage

// File: rtl/memd_arbiter_if.sv
// Requester and memory-side signal bundle; the arbiter uses the slave modport.
interface memd_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          r0_req, r1_req;
  logic          r0_we, r1_we;
  logic          r0_lock, r1_lock;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_gnt, r1_gnt;
  logic          r0_rvalid, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dw;
  logic [DW-1:0] mem_rd;

  modport slave (
    input  r0_req, r1_req, r0_we, r1_we, r0_lock, r1_lock,
    input  r0_addr, r1_addr, r0_wdata, r1_wdata, mem_rd,
    output r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
    output mem_we, mem_addr, mem_dw
  );

  modport master (
    output r0_req, r1_req, r0_we, r1_we, r0_lock, r1_lock,
    output r0_addr, r1_addr, r0_wdata, r1_wdata, mem_rd,
    input  r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
    input  mem_we, mem_addr, mem_dw
  );
endinterface

// File: rtl/memd_arb_rport.sv
// Per-requester read return: captures memory read data on a read grant and
// raises rvalid for exactly the following cycle; rdata holds until the next read.
module memd_arb_rport #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_cap,
  input  logic [DW-1:0] i_rd,
  output logic          o_rvalid,
  output logic [DW-1:0] o_rdata
);
  logic          r_rvalid;
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= i_cap;
      if (i_cap) r_rdata <= i_rd;
    end
  end

  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;
endmodule

// File: rtl/memd_arbiter.sv
// Arbiter between load/store (r0) and debug/loader (r1) in front of the data memory,
// with bounded locked bursts. Define MEMD_ARB_RR_EN for round-robin IDLE tie-breaking.
module memd_arbiter
  import memd_arb_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  memd_arbiter_if.slave  bus
);
  arb_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_g0, w_g1, w_preempt, w_at_max, w_tie1;
  logic             w_we;
  logic [AW-1:0]    w_addr;
  logic [DW-1:0]    w_dw;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

`ifdef MEMD_ARB_RR_EN
  // r_last = side granted most recently; the other side wins the next IDLE tie.
  logic r_last;
  always_ff @(posedge clk) begin
    if (!rst_n)    r_last <= 1'b1;
    else if (w_g0) r_last <= 1'b0;
    else if (w_g1) r_last <= 1'b1;
  end
  assign w_tie1 = ~r_last;
`else
  assign w_tie1 = 1'b0;
`endif

  assign w_at_max = (r_cnt == CNT_W'(MAX_BURST));

  // Grants; an owner that drops req falls through to IDLE arbitration this cycle.
  always_comb begin
    w_g0      = 1'b0;
    w_g1      = 1'b0;
    w_preempt = 1'b0;
    if (rst_n) begin
      if (r_state == ST_OWN0 && bus.r0_req) begin
        if (bus.r1_req && w_at_max) begin
          w_g1      = 1'b1;
          w_preempt = 1'b1;
        end else begin
          w_g0 = 1'b1;
        end
      end else if (r_state == ST_OWN1 && bus.r1_req) begin
        if (bus.r0_req && w_at_max) begin
          w_g0      = 1'b1;
          w_preempt = 1'b1;
        end else begin
          w_g1 = 1'b1;
        end
      end else if (bus.r0_req && bus.r1_req) begin
        w_g1 = w_tie1;
        w_g0 = ~w_tie1;
      end else begin
        w_g0 = bus.r0_req;
        w_g1 = bus.r1_req;
      end
    end
  end

  always_comb begin
    w_state_nxt = ST_IDLE;
    w_cnt_nxt   = '0;
    if (w_preempt) begin
      w_state_nxt = w_g0 ? ST_OWN0 : ST_OWN1;
      w_cnt_nxt   = CNT_W'(1);
    end else if (w_g0 && bus.r0_lock) begin
      w_state_nxt = ST_OWN0;
      w_cnt_nxt   = (r_state == ST_OWN0) ? sat_inc(r_cnt) : CNT_W'(1);
    end else if (w_g1 && bus.r1_lock) begin
      w_state_nxt = ST_OWN1;
      w_cnt_nxt   = (r_state == ST_OWN1) ? sat_inc(r_cnt) : CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Memory-side mux: idles on requester 0's address/data, all zero during reset.
  always_comb begin
    w_we   = 1'b0;
    w_addr = bus.r0_addr;
    w_dw   = bus.r0_wdata;
    if (!rst_n) begin
      w_addr = '0;
      w_dw   = '0;
    end else if (w_g1) begin
      w_we   = bus.r1_we;
      w_addr = bus.r1_addr;
      w_dw   = bus.r1_wdata;
    end else if (w_g0) begin
      w_we   = bus.r0_we;
    end
  end

  assign bus.r0_gnt   = w_g0;
  assign bus.r1_gnt   = w_g1;
  assign bus.mem_we   = w_we;
  assign bus.mem_addr = w_addr;
  assign bus.mem_dw   = w_dw;

  memd_arb_rport #(.DW(DW)) u_rport0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_cap    (w_g0 & ~bus.r0_we),
    .i_rd     (bus.mem_rd),
    .o_rvalid (bus.r0_rvalid),
    .o_rdata  (bus.r0_rdata)
  );

  memd_arb_rport #(.DW(DW)) u_rport1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_cap    (w_g1 & ~bus.r1_we),
    .i_rd     (bus.mem_rd),
    .o_rvalid (bus.r1_rvalid),
    .o_rdata  (bus.r1_rdata)
  );
endmodule

// File: tb/tb_memd_arbiter.sv
// Directed bench for memd_arbiter with a behavioural 32-word sync-write/async-read memory.
module tb_memd_arbiter;
  import memd_arb_pkg::*;

  logic clk;
  logic rst_n;
  logic        pre_we;
  logic [4:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] mem [32];
  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;

  memd_arbiter_if #(.AW(5), .DW(32)) bus ();

  memd_arbiter #(.AW(5), .DW(32), .MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_dw;
  end
  assign bus.mem_rd = mem[bus.mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.r0_req = 1'b0; bus.r1_req = 1'b0;
    bus.r0_we = 1'b0;  bus.r1_we = 1'b0;
    bus.r0_lock = 1'b0; bus.r1_lock = 1'b0;
    bus.r0_addr = '0;  bus.r1_addr = '0;
    bus.r0_wdata = '0; bus.r1_wdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    logic exp0;
    idle_inputs();
    rst_n = 1'b0;
    pre_we = 1'b1; pre_addr = 5'd3; pre_data = 32'hDEADBEEF;
    // Requests during reset must not reach the memory.
    bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 5'd5; bus.r0_wdata = 32'hA5A5A5A5;
    cyc();
    #1;
    chk("rst_gnt0", 32'(bus.r0_gnt), 32'd0);
    chk("rst_gnt1", 32'(bus.r1_gnt), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_dw", bus.mem_dw, 32'd0);
    chk("rst_rvalid0", 32'(bus.r0_rvalid), 32'd0);
    chk("rst_rdata1", bus.r1_rdata, 32'd0);
    chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    idle_inputs();
    cyc();
    rst_n = 1'b1; pre_we = 1'b0;

    // r0 reads preloaded address 3.
    bus.r0_req = 1'b1; bus.r0_addr = 5'd3;
    #1;
    chk("rd_gnt0", 32'(bus.r0_gnt), 32'd1);
    chk("rd_gnt1", 32'(bus.r1_gnt), 32'd0);
    chk("rd_mem_addr", 32'(bus.mem_addr), 32'd3);
    cyc();
    bus.r0_req = 1'b0;
    #1;
    chk("rd_rvalid0", 32'(bus.r0_rvalid), 32'd1);
    chk("rd_rdata0", bus.r0_rdata, 32'hDEADBEEF);
    chk("rd_rvalid1", 32'(bus.r1_rvalid), 32'd0);
    chk("rd_rdata1", bus.r1_rdata, 32'd0);
    cyc();
    chk("rd_rvalid0_drop", 32'(bus.r0_rvalid), 32'd0);
    chk("rd_rdata0_hold", bus.r0_rdata, 32'hDEADBEEF);

    // r1 write then read-back of address 7.
    bus.r1_req = 1'b1; bus.r1_we = 1'b1; bus.r1_addr = 5'd7; bus.r1_wdata = 32'h12345678;
    #1;
    chk("wr_gnt1", 32'(bus.r1_gnt), 32'd1);
    chk("wr_mem_we", 32'(bus.mem_we), 32'd1);
    chk("wr_mem_addr", 32'(bus.mem_addr), 32'd7);
    chk("wr_mem_dw", bus.mem_dw, 32'h12345678);
    cyc();
    bus.r1_we = 1'b0;
    #1;
    chk("rb_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rb_gnt1", 32'(bus.r1_gnt), 32'd1);
    chk("wr_no_rvalid", 32'(bus.r1_rvalid), 32'd0);
    cyc();
    bus.r1_req = 1'b0;
    #1;
    chk("rb_rvalid1", 32'(bus.r1_rvalid), 32'd1);
    chk("rb_rdata1", bus.r1_rdata, 32'h12345678);
    chk("rb_idle_mem_we", 32'(bus.mem_we), 32'd0);

    // IDLE ties without lock.
    do_reset();
    bus.r0_req = 1'b1; bus.r1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef MEMD_ARB_RR_EN
      exp0 = (i % 2 == 0);
`else
      exp0 = 1'b1;
`endif
      #1;
      chk($sformatf("tie_gnt0_%0d", i), 32'(bus.r0_gnt), 32'(exp0));
      chk($sformatf("tie_gnt1_%0d", i), 32'(bus.r1_gnt), 32'(!exp0));
      cyc();
    end
    idle_inputs();

    // r0 locked burst against a waiting r1: bounded at 4 grants.
    do_reset();
    bus.r0_req = 1'b1; bus.r0_lock = 1'b1; bus.r1_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("burst_gnt0_c%0d", c), 32'(bus.r0_gnt), 32'(c <= 4));
      chk($sformatf("burst_gnt1_c%0d", c), 32'(bus.r1_gnt), 32'(c == 5));
      cyc();
    end
    chk("burst_state_own1", 32'(dut.r_state), 32'(ST_OWN1));
    idle_inputs();

    // Reset in the second cycle of a locked r1 read burst.
    do_reset();
    bus.r1_req = 1'b1; bus.r1_lock = 1'b1; bus.r1_addr = 5'd3;
    #1;
    chk("rb1_gnt1", 32'(bus.r1_gnt), 32'd1);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("rb2_gnt1_forced", 32'(bus.r1_gnt), 32'd0);
    chk("rb2_rvalid1_prev", 32'(bus.r1_rvalid), 32'd1);
    cyc();
    rst_n = 1'b1;
    bus.r1_req = 1'b0; bus.r1_lock = 1'b0;
    bus.r0_req = 1'b1; bus.r0_addr = 5'd3;
    #1;
    chk("rb3_state_idle", 32'(dut.r_state), 32'(ST_IDLE));
    chk("rb3_no_rvalid1", 32'(bus.r1_rvalid), 32'd0);
    chk("rb3_gnt0", 32'(bus.r0_gnt), 32'd1);
    cyc();
    idle_inputs();

    // Randomised mix: grant exclusivity and no stray writes.
    for (int k = 0; k < 300; k++) begin
      bus.r0_req   = 1'($urandom_range(0, 1));
      bus.r1_req   = 1'($urandom_range(0, 1));
      bus.r0_we    = 1'($urandom_range(0, 1));
      bus.r1_we    = 1'($urandom_range(0, 1));
      bus.r0_lock  = 1'($urandom_range(0, 1));
      bus.r1_lock  = 1'($urandom_range(0, 1));
      bus.r0_addr  = 5'($urandom_range(0, 31));
      bus.r1_addr  = 5'($urandom_range(0, 31));
      bus.r0_wdata = $urandom;
      bus.r1_wdata = $urandom;
      #1;
      chk("rand_excl", 32'(bus.r0_gnt & bus.r1_gnt), 32'd0);
      chk("rand_no_gnt_we", 32'(bus.mem_we & ~(bus.r0_gnt | bus.r1_gnt)), 32'd0);
      cyc();
    end
    idle_inputs();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
